pipeline_mem_arbiter: RTL and testbench

- Sequences the single-ported RAM between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage).
- Registered grant FSM. Data requests take priority; a starvation counter guarantees fetch progress.
- Produces ihit/dhit, which the hazard unit consumes for stage enables and flushes.
- Sits between the datapath and the RAM model.

---
 rtl/arb_pkg.sv | 10 +
 rtl/cpu_types_pkg.sv | 13 +
 rtl/arb_perf_cnt.sv | 26 ++
 rtl/pipeline_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Grant-FSM states and starvation counter width for the fetch/data RAM arbiter.
package arb_pkg;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU word and RAM status types used by the memory-side blocks.
package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/arb_perf_cnt.sv
// Grant and stall counters for the RAM arbiter; compiled only with ARB_PERF_CNT_EN.
`ifdef ARB_PERF_CNT_EN
module arb_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_done,
    input  logic        d_done,
    input  logic        stall,
    output logic [31:0] i_grant_cnt,
    output logic [31:0] d_grant_cnt,
    output logic [31:0] stall_cnt
);
    // All three wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (i_done) i_grant_cnt <= i_grant_cnt + 32'd1;
            if (d_done) d_grant_cnt <= d_grant_cnt + 32'd1;
            if (stall)  stall_cnt   <= stall_cnt + 32'd1;
        end
    end
endmodule
`endif

// File: rtl/pipeline_mem_arbiter.sv
// Single-port RAM arbiter between IF fetch and MEM data ports, data-priority with fetch anti-starvation.
// Optional ARB_PERF_CNT_EN adds grant/stall performance counters.
module pipeline_mem_arbiter
    import cpu_types_pkg::*;
    import arb_pkg::*;
#(
    parameter int I_STARVE_LIMIT = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dhit,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  ramstate_t         ramstate
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(I_STARVE_LIMIT);

    arb_state_t          state, next_state;
    logic [STARVE_W-1:0] starve_cnt;
    logic                dreq, i_done, d_done, i_forced;

    assign dreq     = dREN | dWEN;
    // A completion needs the request still present; a dropped request is an abort.
    assign i_done   = (state == SERVE_I) && iREN && (ramstate == ACCESS);
    assign d_done   = (state == SERVE_D) && dreq && (ramstate == ACCESS);
    assign i_forced = iREN && (starve_cnt == LIMIT);

    assign ihit  = i_done;
    assign dhit  = d_done;
    assign iload = i_done ? ramload : '0;
    assign dload = (d_done && !dWEN) ? ramload : '0;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            SERVE_I: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                end
            end
            SERVE_D: begin
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr;
                    ramstore = dstore;
                end else if (dREN) begin
                    ramREN  = 1'b1;
                    ramaddr = daddr;
                end
            end
            default: ;
        endcase
    end

    // On completion the finished requester is masked, so the other one follows with no bubble.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq && !i_forced) next_state = SERVE_D;
                else if (iREN)         next_state = SERVE_I;
                else                   next_state = IDLE;
            end
            SERVE_I: begin
                if (!iREN)       next_state = IDLE;
                else if (i_done) next_state = dreq ? SERVE_D : IDLE;
            end
            SERVE_D: begin
                if (!dreq)       next_state = IDLE;
                else if (d_done) next_state = iREN ? SERVE_I : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state <= next_state;
            if (!iREN || i_done)
                starve_cnt <= '0;
            else if (d_done && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef ARB_PERF_CNT_EN
    arb_perf_cnt u_perf (
        .clk         (CLK),
        .rst_n       (nRST),
        .i_done      (i_done),
        .d_done      (d_done),
        .stall       ((iREN | dreq) && !i_done && !d_done),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt),
        .stall_cnt   (stall_cnt)
    );
`endif
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: directed vector table, reset/perf sequences, randomized model compare.
module tb_pipeline_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 2;
    localparam logic [31:0] IA = 32'h0000_0040;
    localparam logic [31:0] DA = 32'h0000_0100;
    localparam logic [31:0] DS = 32'hDEAD_0001;
    localparam logic [31:0] RL = 32'h8C22_0004;
    localparam logic [31:0] DL = 32'h1111_2222;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic        ihit, dhit, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] i_grant_cnt, d_grant_cnt, stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    pipeline_mem_arbiter #(.I_STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef ARB_PERF_CNT_EN
        ,
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        logic        iren, dren, dwen;
        ramstate_t   rs;
        logic [31:0] rload;
        logic        ih, dh, rr, rw;
        logic [31:0] addr, store, il, dl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iren, logic dren, logic dwen, ramstate_t rs, logic [31:0] rload,
                                logic ih, logic dh, logic rr, logic rw,
                                logic [31:0] addr, logic [31:0] store, logic [31:0] il, logic [31:0] dl);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.rload = rload;
        v.ih = ih; v.dh = dh; v.rr = rr; v.rw = rw;
        v.addr = addr; v.store = store; v.il = il; v.dl = dl;
        return v;
    endfunction

    function automatic logic [131:0] outs();
        return {ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, iload, dload};
    endfunction

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic ir, input logic dr, input logic dw, input ramstate_t rs, input logic [31:0] rl);
        iREN = ir; dREN = dr; dWEN = dw; ramstate = rs; ramload = rl;
    endtask

    // Transaction-level reference: who owns the RAM and how many data wins the fetch has sat through.
    int owner;   // 0 none, 1 fetch, 2 data
    int starve;

    initial begin
        logic [131:0] exp;
        logic [31:0]  s0, g0;
        nRST = 1'b0;
        iaddr = IA; daddr = DA; dstore = DS;
        drive(1'b1, 1'b0, 1'b1, ACCESS, RL);
        repeat (2) @(negedge CLK);
        #1 check("reset_outputs", outs(), '0);
        drive(1'b0, 1'b0, 1'b0, FREE, '0);
        @(negedge CLK) nRST = 1'b1;

        // Fetch only, simultaneous, back-to-back alternation, abort, ERROR retry, read+write collision
        tbl.push_back(mk(1,0,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(1,0,0,BUSY,  '0, 0,0,1,0, IA,'0,'0,'0));
        tbl.push_back(mk(1,0,0,BUSY,  '0, 0,0,1,0, IA,'0,'0,'0));
        tbl.push_back(mk(1,0,0,ACCESS,RL, 1,0,1,0, IA,'0,RL,'0));
        tbl.push_back(mk(0,0,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(1,1,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(1,1,0,ACCESS,DL, 0,1,1,0, DA,'0,'0,DL));
        tbl.push_back(mk(1,0,0,ACCESS,RL, 1,0,1,0, IA,'0,RL,'0));
        tbl.push_back(mk(0,0,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(1,0,1,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(1,0,1,ACCESS,RL, 0,1,0,1, DA,DS,'0,'0));
        tbl.push_back(mk(1,0,1,ACCESS,RL, 1,0,1,0, IA,'0,RL,'0));
        tbl.push_back(mk(1,0,1,ACCESS,RL, 0,1,0,1, DA,DS,'0,'0));
        tbl.push_back(mk(1,0,0,ACCESS,RL, 1,0,1,0, IA,'0,RL,'0));
        tbl.push_back(mk(0,0,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(1,0,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(1,0,0,BUSY,  '0, 0,0,1,0, IA,'0,'0,'0));
        tbl.push_back(mk(1,0,0,BUSY,  '0, 0,0,1,0, IA,'0,'0,'0));
        tbl.push_back(mk(0,0,0,BUSY,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(0,0,0,ACCESS,RL, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(0,1,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(0,1,0,ERROR, DL, 0,0,1,0, DA,'0,'0,'0));
        tbl.push_back(mk(0,1,0,ACCESS,DL, 0,1,1,0, DA,'0,'0,DL));
        tbl.push_back(mk(0,0,0,ACCESS,DL, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(0,1,1,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));
        tbl.push_back(mk(0,1,1,ACCESS,DL, 0,1,0,1, DA,DS,'0,'0));
        tbl.push_back(mk(0,0,0,FREE,  '0, 0,0,0,0, '0,'0,'0,'0));

        foreach (tbl[k]) begin
            @(negedge CLK);
            drive(tbl[k].iren, tbl[k].dren, tbl[k].dwen, tbl[k].rs, tbl[k].rload);
            #1;
            exp = {tbl[k].ih, tbl[k].dh, tbl[k].rr, tbl[k].rw, tbl[k].addr, tbl[k].store, tbl[k].il, tbl[k].dl};
            check($sformatf("vec%0d", k), outs(), exp);
        end

        // Reset in the middle of a write: strobe must drop without waiting for a clock.
        @(negedge CLK) drive(1'b0, 1'b0, 1'b1, FREE, '0);
        @(negedge CLK) drive(1'b0, 1'b0, 1'b1, BUSY, '0);
        #1 check("mid_write_strobe", outs(), {4'b0001, DA, DS, 64'd0});
        #2 nRST = 1'b0;
        #1 check("async_reset_drop", outs(), '0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, ACCESS, RL);
        #1 check("post_reset_idle", outs(), '0);
        @(negedge CLK);
        #1 check("post_reset_fetch", outs(), {4'b1010, IA, 32'd0, RL, 32'd0});
        @(negedge CLK) drive(1'b0, 1'b0, 1'b0, FREE, '0);

`ifdef ARB_PERF_CNT_EN
        // ERROR retry: the arbitration cycle and the ERROR cycle are both stalls.
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, FREE, '0);
        s0 = stall_cnt; g0 = d_grant_cnt;
        @(negedge CLK) drive(1'b0, 1'b1, 1'b0, ERROR, '0);
        @(negedge CLK) drive(1'b0, 1'b1, 1'b0, ACCESS, DL);
        @(negedge CLK) drive(1'b0, 1'b0, 1'b0, FREE, '0);
        check32("perf_stall_delta", stall_cnt - s0, 32'd2);
        check32("perf_dgrant_delta", d_grant_cnt - g0, 32'd1);
`else
        s0 = '0; g0 = '0;
`endif

        // Randomized phase against the reference, starting from a clean reset.
        @(negedge CLK) nRST = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        owner = 0; starve = 0;
        for (int c = 0; c < 2000; c++) begin
            logic        e_ih, e_dh, e_rr, e_rw, dq;
            logic [31:0] e_addr, e_store, e_il, e_dl;
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) dREN = ~dREN;
            if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
            ramstate = ramstate_t'($urandom_range(0, 3));
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            #1;
            dq = dREN | dWEN;
            e_ih = 0; e_dh = 0; e_rr = 0; e_rw = 0;
            e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
            if (owner == 1 && iREN) begin
                e_rr = 1; e_addr = iaddr;
                if (ramstate == ACCESS) begin e_ih = 1; e_il = ramload; end
            end
            if (owner == 2 && dq) begin
                e_addr = daddr;
                if (dWEN) begin e_rw = 1; e_store = dstore; end
                else e_rr = 1;
                if (ramstate == ACCESS) begin
                    e_dh = 1;
                    if (!dWEN) e_dl = ramload;
                end
            end
            check($sformatf("rand%0d", c), outs(), {e_ih, e_dh, e_rr, e_rw, e_addr, e_store, e_il, e_dl});
            case (owner)
                0:       owner = (dq && !(iREN && starve == LIMIT)) ? 2 : (iREN ? 1 : 0);
                1:       owner = !iREN ? 0 : (e_ih ? (dq ? 2 : 0) : 1);
                default: owner = !dq ? 0 : (e_dh ? (iREN ? 1 : 0) : 2);
            endcase
            if (!iREN || e_ih) starve = 0;
            else if (e_dh && starve < LIMIT) starve++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
